div_32_seq: RTL and testbench
=============================

// Module: div_32_seq
// PURPOSE
//  Multi-cycle 32-bit non-restoring divider on the ALU path, downstream of add_32.
//  Takes dividend/divisor from the operand bus on start.
//  Iterates one quotient bit per cycle, using add_32 as its add/subtract engine.
//  Returns quotient for LO and remainder for HI with a start/busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand width; only 32 supported (add_32 is fixed width)
//  CNT_W  6   iteration counter width, >= clog2(WIDTH)+1
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   request; sampled only in IDLE
//  dividend   in   32  captured on accepted start
//  divisor    in   32  captured on accepted start
//  busy       out  1   high from cycle after accepted start until done
//  done       out  1   one-cycle pulse; quotient/remainder valid from this cycle
//  div0       out  1   divide-by-zero flag, valid with done, held until next start
//  quotient   out  32  result for LO, held until next accepted start
//  remainder  out  32  result for HI, held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy, done and div0 are 0; quotient and remainder are 0.
//  Reset mid-operation aborts the operation; no done pulse is issued.
//  States:
//   IDLE: start=1 -> latch operands, clear div0.
//    divisor==0 -> DONE, else PREP.
//   PREP, 1 cycle: take magnitudes and record sign bits (signed build only).
//    Clear partial remainder R (33b), load Q=|dividend|, cnt=0 -> ITER.
//   ITER, 32 cycles: shift {R,Q} left 1.
//    R>=0: R=R-|D|; else R=R+|D|.
//    Q[0]=~R[32]; cnt++; cnt==31 -> FIX.
//   FIX, 1 cycle: R<0 -> R=R+|D|.
//    Apply signs: quotient negated if sign(dividend)^sign(divisor); remainder takes sign of dividend -> DONE.
//   DONE, 1 cycle: done=1, busy=0 -> IDLE.
//  Latency: start sampled at edge N; done high in cycle N+35.
//   Divide-by-zero: done in cycle N+1.
//  Divide-by-zero: div0=1, quotient=32'hFFFF_FFFF, remainder=dividend.
//  Signed overflow (32'h8000_0000 / -1): quotient=32'h8000_0000, remainder=0, div0=0.
//  start while busy or in DONE is ignored; the caller must re-issue it after done.
//  start in the cycle after done is accepted; back-to-back operation is legal.
//  Quotient truncates toward zero.
//  All add/subtract uses add_32 (Cin=1 with ~B for subtract); bit 32 of R comes from Cout logic.
// CONFIGURATION
//  DIV_SIGNED_EN defined: two's-complement signed divide; PREP/FIX perform sign handling.
//  DIV_SIGNED_EN undefined: unsigned divide.
//   PREP passes operands unchanged; FIX does remainder restore only.
//   Latency is unchanged at 35.
// STRUCTURE
//  Shared package cpu_div_pkg holds:
//   state encoding DIV_IDLE, DIV_PREP, DIV_ITER, DIV_FIX, DIV_DONE (3b);
//   DIV_ITERS=32; DIV0_QUOT=32'hFFFF_FFFF.
//  Sub-module div_step is one non-restoring iteration, built around one add_32.
//   Input: R, Q, |D|. Output: next R, Q.
//  Top holds the FSM, counter, sign regs, result regs and negation via add_32 (~x + 1).
// TESTING
//  100 / 7 -> quotient=14, remainder=2, div0=0, done exactly 35 cycles after start.
//  -100 / 7 (DIV_SIGNED_EN) -> quotient=32'hFFFF_FFF2, remainder=32'hFFFF_FFFE.
//  5 / 0 -> done after 1 cycle, div0=1, quotient=32'hFFFF_FFFF, remainder=5.
//  32'h8000_0000 / 32'hFFFF_FFFF (signed) -> quotient=32'h8000_0000, remainder=0.
//   Unsigned build: 32'hFFFF_FFFF / 2 -> quotient=32'h7FFF_FFFF, remainder=1.
//  Second start while busy at iteration 10 -> ignored, first result unaltered.
//   rst_n low at iteration 20 -> busy/done/quotient/remainder=0 immediately, FSM in IDLE.
//  Random signed/unsigned pairs with back-to-back starts vs reference model:
//   check quotient*divisor + remainder == dividend and |remainder| < |divisor|.

Source files
------------

// File: rtl/cpu_div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and result constants.
package cpu_div_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/add_32.sv
// 32-bit adder with carry in/out; the ALU's shared add/subtract engine.
module add_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {r,q} left, then add or subtract the divisor.
module div_step (
  input  logic [32:0] r,
  input  logic [31:0] q,
  input  logic [31:0] d,
  output logic [32:0] r_next,
  output logic [31:0] q_next
);

  logic        sub;
  logic [32:0] r_shift;
  logic [31:0] sum;
  logic        cout;

  assign sub     = ~r[32];
  assign r_shift = {r[31:0], q[31]};

  add_32 u_add (
    .a    (r_shift[31:0]),
    .b    (sub ? ~d : d),
    .cin  (sub),
    .sum  (sum),
    .cout (cout)
  );

  // Bit 32 of the 33-bit sum: operand bit 32 of ~{0,d} is 1 when subtracting.
  assign r_next = {r_shift[32] ^ sub ^ cout, sum};
  assign q_next = {q[30:0], ~r_next[32]};

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle 32-bit non-restoring divider, quotient to LO and remainder to HI.
// Define DIV_SIGNED_EN for two's-complement signed divide; default is unsigned.
module div_32_seq
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_restored;
  logic             restore_cout_unused;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] q_load;
  logic [WIDTH-1:0] d_load;

  div_step u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Final correction: a negative partial remainder gets the divisor added back.
  add_32 u_restore (
    .a    (r_reg[WIDTH-1:0]),
    .b    (d_reg),
    .cin  (1'b0),
    .sum  (r_restored),
    .cout (restore_cout_unused)
  );

  assign rem_mag = r_reg[WIDTH] ? r_restored : r_reg[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic             sign_a;
  logic             sign_d;
  logic [WIDTH-1:0] neg_a_sum;
  logic [WIDTH-1:0] neg_b_sum;
  logic             neg_a_cout_unused;
  logic             neg_b_cout_unused;

  // Two negators shared between PREP (operand magnitudes) and FIX (result signs).
  add_32 u_neg_a (
    .a    ((state == DIV_PREP) ? ~a_reg : ~q_reg),
    .b    (32'd0),
    .cin  (1'b1),
    .sum  (neg_a_sum),
    .cout (neg_a_cout_unused)
  );

  add_32 u_neg_b (
    .a    ((state == DIV_PREP) ? ~d_reg : ~rem_mag),
    .b    (32'd0),
    .cin  (1'b1),
    .sum  (neg_b_sum),
    .cout (neg_b_cout_unused)
  );

  assign q_load   = a_reg[WIDTH-1] ? neg_a_sum : a_reg;
  assign d_load   = d_reg[WIDTH-1] ? neg_b_sum : d_reg;
  assign quot_fix = (sign_a ^ sign_d) ? neg_a_sum : q_reg;
  assign rem_fix  = sign_a ? neg_b_sum : rem_mag;

  always_ff @(posedge clk) begin
    if (state == DIV_PREP) begin
      sign_a <= a_reg[WIDTH-1];
      sign_d <= d_reg[WIDTH-1];
    end
  end
`else
  assign q_load   = a_reg;
  assign d_load   = d_reg;
  assign quot_fix = q_reg;
  assign rem_fix  = rem_mag;
`endif

  // Datapath registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    case (state)
      DIV_IDLE: begin
        if (start) begin
          a_reg <= dividend;
          d_reg <= divisor;
        end
      end
      DIV_PREP: begin
        r_reg <= '0;
        q_reg <= q_load;
        d_reg <= d_load;
      end
      DIV_ITER: begin
        r_reg <= r_next;
        q_reg <= q_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            div0 <= 1'b0;
            if (divisor == '0) begin
              div0      <= 1'b1;
              quotient  <= DIV0_QUOT;
              remainder <= dividend;
              done      <= 1'b1;
              state     <= DIV_DONE;
            end else begin
              busy  <= 1'b1;
              state <= DIV_PREP;
            end
          end
        end
        DIV_PREP: begin
          cnt   <= '0;
          state <= DIV_ITER;
        end
        DIV_ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          quotient  <= quot_fix;
          remainder <= rem_fix;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq against an arithmetic reference model.
module tb_div_32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;

  div_32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  function automatic logic [32:0] mag(input logic [31:0] x);
`ifdef DIV_SIGNED_EN
    mag = x[31] ? (33'd0 - {x[31], x}) : {1'b0, x};
`else
    mag = {1'b0, x};
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 of the done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int cycles, output bit ok);
    if (done === 1'b1) begin
      @(posedge clk); #1;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    ok = (done === 1'b1);
    q = quotient; r = remainder; z = div0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %0b want 0", div0); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quot got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_rem got %h want 0", remainder); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] q, r; logic z; int cyc; bit ok;
    do_op(32'd100, 32'd7, q, r, z, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout cycles %0d", cyc); end
    checks++; if (cyc != 35) begin errors++; $display("FAIL basic_latency got %0d want 35", cyc); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL basic_quot got %h want 0000000e", q); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL basic_rem got %h want 00000002", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_div0 got %0b want 0", z); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %0b want 0", busy); end
  endtask

  task automatic test_div0();
    logic [31:0] q, r; logic z; int cyc; bit ok;
    do_op(32'd5, 32'd0, q, r, z, cyc, ok);
    checks++; if (cyc != 1 || !ok) begin errors++; $display("FAIL div0_latency got %0d want 1", cyc); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL div0_flag got %0b want 1", z); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_quot got %h want ffffffff", q); end
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL div0_rem got %h want 00000005", r); end
    @(posedge clk); #1;
    checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_hold got %0b want 1", div0); end
  endtask

  task automatic test_edges();
    logic [31:0] q, r; logic z; int cyc; bit ok;
`ifdef DIV_SIGNED_EN
    do_op(32'hFFFF_FF9C, 32'd7, q, r, z, cyc, ok);
    checks++; if (q !== 32'hFFFF_FFF2) begin errors++; $display("FAIL neg100_quot got %h want fffffff2", q); end
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL neg100_rem got %h want fffffffe", r); end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, cyc, ok);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL ovf_quot got %h want 80000000", q); end
    checks++; if (r !== 32'd0 || z !== 1'b0) begin errors++; $display("FAIL ovf_rem got %h/%0b want 0/0", r, z); end
    checks++; if (cyc != 35) begin errors++; $display("FAIL ovf_latency got %0d want 35", cyc); end
`else
    do_op(32'hFFFF_FFFF, 32'd2, q, r, z, cyc, ok);
    checks++; if (q !== 32'h7FFF_FFFF) begin errors++; $display("FAIL umax_quot got %h want 7fffffff", q); end
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL umax_rem got %h want 00000001", r); end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, cyc, ok);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL ubig_quot got %h want 0", q); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL ubig_rem got %h want 80000000", r); end
    checks++; if (cyc != 35) begin errors++; $display("FAIL ubig_latency got %0d want 35", cyc); end
`endif
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, eq, er; logic ez; int cyc;
    a = $urandom; b = 32'd13;
    ref_div(a, b, eq, er, ez);
    if (done === 1'b1) begin @(posedge clk); #1; end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 12) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %0b want 1", busy); end
        start = 1'b1; dividend = $urandom; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc != 35) begin errors++; $display("FAIL ignore_latency got %0d want 35", cyc); end
    checks++; if (quotient !== eq) begin errors++; $display("FAIL ignore_quot got %h want %h", quotient, eq); end
    checks++; if (remainder !== er) begin errors++; $display("FAIL ignore_rem got %h want %h", remainder, er); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_second_op busy %0b done %0b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int seen;
    if (done === 1'b1) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 32'd123456; divisor = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl busy %0b done %0b want 0 0", busy, done); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL midrst_data got %h %h want 0 0", quotient, remainder); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, q, r, eq, er; logic z, ez; int cyc; bit ok;
    logic [32:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 15));
        1: b = $urandom;
        2: b = $urandom >> $urandom_range(0, 31);
        3: b = 32'd0 - 32'($urandom_range(1, 9));
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      endcase
      ref_div(a, b, eq, er, ez);
      do_op(a, b, q, r, z, cyc, ok);
      checks++;
      if (!ok || q !== eq || r !== er || z !== ez || cyc != (ez ? 1 : 35)) begin
        errors++;
        $display("FAIL rand_%0d a=%h b=%h got q=%h r=%h z=%0b cyc=%0d want q=%h r=%h z=%0b", i, a, b, q, r, z, cyc, eq, er, ez);
      end
      if (!ez) begin
        ra = mag(r); rb = mag(b);
        checks++;
        if (q * b + r !== a || ra >= rb) begin
          errors++;
          $display("FAIL rand_identity_%0d a=%h b=%h q=%h r=%h", i, a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_edges();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
